// File: rtl/nba_commit_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : nba_commit_scheduler_if
// Purpose  : Bundles the request, commit and publish signals of the NBA commit
//            scheduler so producers and the scheduler connect through one port.
// Ports    : master - requesters / controller side (drives requests, commit,
//                     clr_ovf; observes grants, busy, var_q, change, overflow)
//            slave  - scheduler side (mirror of master)
// Revision : 1.0 - initial release
// ============================================================================
interface nba_commit_scheduler_if #(
  parameter int NREQ = 2,
  parameter int NVAR = 4,
  parameter int W    = 8
);
  localparam int VW = (NVAR > 1) ? $clog2(NVAR) : 1;

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*VW-1:0] req_var;
  logic [NREQ*W-1:0]  req_data;
  logic [NREQ-1:0]    req_ready;
  logic               commit;
  logic               busy;
  logic [NVAR*W-1:0]  var_q;
  logic [NVAR-1:0]    change;
  logic               overflow;
  logic               clr_ovf;

  modport master (
    output req_valid, req_var, req_data, commit, clr_ovf,
    input  req_ready, busy, var_q, change, overflow
  );

  modport slave (
    input  req_valid, req_var, req_data, commit, clr_ovf,
    output req_ready, busy, var_q, change, overflow
  );
endinterface
`default_nettype wire

// File: rtl/nba_commit_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : nba_commit_scheduler
// Purpose  : Collects deferred writes from NREQ requesters into an arrival-
//            ordered queue and, on commit, applies them as one atomic batch to
//            a small variable file. A per-variable change pulse fires only when
//            a variable's committed value differs from its pre-commit value.
// Ports    : clk   - clock, rising edge
//            rst_n - asynchronous active-low reset
//            bus   - slave modport: req_valid/req_var/req_data/req_ready
//                    (round-robin one-hot grant), commit, busy, var_q,
//                    change, overflow (sticky), clr_ovf
// Revision : 1.0 - initial release
// ============================================================================
module nba_commit_scheduler #(
  parameter int NREQ  = 2,
  parameter int NVAR  = 4,
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  wire                   clk,
  input  wire                   rst_n,
  nba_commit_scheduler_if.slave bus
);
  localparam int VW = (NVAR > 1) ? $clog2(NVAR) : 1;
  localparam int PW = $clog2(DEPTH);
  localparam int RW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRAIN  = 2'd1,
    S_NOTIFY = 2'd2
  } state_e;

  state_e          state_q, state_d;

  // Queue pointers carry one extra bit so full and empty are distinguishable.
  logic [PW:0]     wr_ptr_q, wr_ptr_d;
  logic [PW:0]     rd_ptr_q, rd_ptr_d;
  logic [PW:0]     rd_ptr_inc;
  logic [RW-1:0]   rr_q, rr_d;

  logic [VW-1:0]   qvar_mem  [DEPTH];
  logic [W-1:0]    qdata_mem [DEPTH];

  logic [W-1:0]    vars_q   [NVAR];
  logic [W-1:0]    work_q   [NVAR];
  logic [W-1:0]    shadow_q [NVAR];
  logic [NVAR-1:0] change_q, change_d;
  logic            overflow_q, overflow_d;

  logic            q_empty, q_full;
  logic [NREQ-1:0] gnt;
  logic            gnt_any;
  logic [RW-1:0]   gnt_idx;
  logic [RW-1:0]   cand;
  logic [VW-1:0]   enq_var;
  logic [W-1:0]    enq_data;
  logic [VW-1:0]   head_var;
  logic [W-1:0]    head_data;
  logic            head_ok;
  logic            snap, pop_en, publish, busy;

  assign busy       = (state_q != S_IDLE);
  assign q_empty    = (wr_ptr_q == rd_ptr_q);
  assign q_full     = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                      (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign rd_ptr_inc = rd_ptr_q + {{PW{1'b0}}, 1'b1};

  assign head_var   = qvar_mem[rd_ptr_q[PW-1:0]];
  assign head_data  = qdata_mem[rd_ptr_q[PW-1:0]];
  // Out-of-range targets are still popped, just never written.
  assign head_ok    = (int'(head_var) < NVAR);

  // Round-robin arbiter: scan from the pointer, first valid requester wins.
  always_comb begin
    gnt     = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    if (state_q == S_IDLE && !q_full) begin
      for (int off = 0; off < NREQ; off++) begin
        cand = RW'((int'(rr_q) + off) % NREQ);
        if (!gnt_any && bus.req_valid[cand]) begin
          gnt_any   = 1'b1;
          gnt_idx   = cand;
          gnt[cand] = 1'b1;
        end
      end
    end
    rr_d = gnt_any ? RW'((int'(gnt_idx) + 1) % NREQ) : rr_q;
  end

  always_comb begin
    enq_var  = '0;
    enq_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        enq_var  = bus.req_var[i*VW +: VW];
        enq_data = bus.req_data[i*W +: W];
      end
    end
  end

  // FSM next-state and control strobes.
  always_comb begin
    state_d  = state_q;
    snap     = 1'b0;
    pop_en   = 1'b0;
    publish  = 1'b0;
    change_d = '0;
    case (state_q)
      S_IDLE: begin
        if (bus.commit) begin
          snap = 1'b1;
          // A same-edge enqueue joins this batch, so it counts as non-empty.
          state_d = (q_empty && !gnt_any) ? S_NOTIFY : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!q_empty) begin
          pop_en = 1'b1;
          if (rd_ptr_inc == wr_ptr_q) state_d = S_NOTIFY;
        end else begin
          state_d = S_NOTIFY;
        end
      end
      S_NOTIFY: begin
        publish = 1'b1;
        state_d = S_IDLE;
        for (int v = 0; v < NVAR; v++) begin
          change_d[v] = (work_q[v] != shadow_q[v]);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{PW{1'b0}}, gnt_any};
    rd_ptr_d = rd_ptr_q + {{PW{1'b0}}, pop_en};
    // A fresh overflow wins over a simultaneous clear.
    if (bus.commit && busy)  overflow_d = 1'b1;
    else if (bus.clr_ovf)    overflow_d = 1'b0;
    else                     overflow_d = overflow_q;
  end

  // Queue storage carries no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (gnt_any) begin
      qvar_mem[wr_ptr_q[PW-1:0]]  <= enq_var;
      qdata_mem[wr_ptr_q[PW-1:0]] <= enq_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rr_q       <= '0;
      change_q   <= '0;
      overflow_q <= 1'b0;
      for (int v = 0; v < NVAR; v++) begin
        vars_q[v]   <= '0;
        work_q[v]   <= '0;
        shadow_q[v] <= '0;
      end
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rr_q       <= rr_d;
      change_q   <= change_d;
      overflow_q <= overflow_d;
      if (snap) begin
        for (int v = 0; v < NVAR; v++) begin
          shadow_q[v] <= vars_q[v];
          work_q[v]   <= vars_q[v];
        end
      end
      if (pop_en && head_ok) work_q[head_var] <= head_data;
      // All variables move together; intermediate batch values stay hidden.
      if (publish) begin
        for (int v = 0; v < NVAR; v++) vars_q[v] <= work_q[v];
      end
    end
  end

  generate
    for (genvar v = 0; v < NVAR; v++) begin : g_var_out
      assign bus.var_q[v*W +: W] = vars_q[v];
    end
  endgenerate

  assign bus.req_ready = gnt;
  assign bus.busy      = busy;
  assign bus.change    = change_q;
  assign bus.overflow  = overflow_q;
endmodule
`default_nettype wire

// File: tb/tb_nba_commit_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_nba_commit_scheduler
// Purpose  : Self-checking bench for nba_commit_scheduler. A batch-level
//            reference model (queue of writes, applied all at once on commit
//            with a k+1 cycle latency counter) is compared against the DUT on
//            every falling edge; directed scenarios add literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nba_commit_scheduler;
  localparam int NREQ  = 2;
  localparam int NVAR  = 4;
  localparam int W     = 8;
  localparam int DEPTH = 8;
  localparam int VW    = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  nba_commit_scheduler_if #(.NREQ(NREQ), .NVAR(NVAR), .W(W)) bus ();

  nba_commit_scheduler #(.NREQ(NREQ), .NVAR(NVAR), .W(W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { int v; int d; } wr_t;
  wr_t             mq[$];
  int              mvars [NVAR];
  int              mfinal[NVAR];
  int              mrr;
  int              mbusy_left;
  logic [NVAR-1:0] mmask;
  logic [NVAR-1:0] mchange;
  logic            movf;
  int              mg;
  logic [NREQ-1:0] exp_rdy;
  logic [NVAR*W-1:0] exp_vars;
  wr_t             me;

  task automatic model_reset();
    mq.delete();
    for (int v = 0; v < NVAR; v++) begin mvars[v] = 0; mfinal[v] = 0; end
    mrr = 0; mbusy_left = 0; mmask = '0; mchange = '0; movf = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst_n) model_reset();
    mg = -1;
    exp_rdy = '0;
    if (mbusy_left == 0 && mq.size() < DEPTH) begin
      for (int off = 0; off < NREQ; off++) begin
        if (mg < 0 && bus.req_valid[(mrr + off) % NREQ]) mg = (mrr + off) % NREQ;
      end
    end
    if (mg >= 0) exp_rdy[mg] = 1'b1;
    for (int v = 0; v < NVAR; v++) exp_vars[v*W +: W] = W'(mvars[v]);

    chk("m_ready",    bus.req_ready, exp_rdy);
    chk("m_busy",     bus.busy,      (mbusy_left > 0));
    chk("m_overflow", bus.overflow,  movf);
    chk("m_var_q",    bus.var_q,     exp_vars);
    chk("m_change",   bus.change,    mchange);

    if (rst_n) begin
      if (mg >= 0) begin
        me.v = int'(bus.req_var[mg*VW +: VW]);
        me.d = int'(bus.req_data[mg*W +: W]);
        mq.push_back(me);
        mrr = (mg + 1) % NREQ;
      end
      if (bus.commit && mbusy_left > 0) movf = 1'b1;
      else if (bus.clr_ovf)             movf = 1'b0;
      mchange = '0;
      if (mbusy_left > 0) begin
        mbusy_left--;
        if (mbusy_left == 0) begin
          for (int v = 0; v < NVAR; v++) mvars[v] = mfinal[v];
          mchange = mmask;
        end
      end else if (bus.commit) begin
        for (int v = 0; v < NVAR; v++) mfinal[v] = mvars[v];
        foreach (mq[i]) if (mq[i].v < NVAR) mfinal[mq[i].v] = mq[i].d;
        for (int v = 0; v < NVAR; v++) mmask[v] = (mfinal[v] != mvars[v]);
        mbusy_left = mq.size() + 1;
        mq.delete();
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic enq(input int r, input int v, input int d);
    bus.req_valid = '0;
    bus.req_valid[r] = 1'b1;
    bus.req_var[r*VW +: VW] = VW'(v);
    bus.req_data[r*W +: W]  = W'(d);
    cyc();
    bus.req_valid = '0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (bus.busy && n < 100) begin n++; cyc(); end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL busy_timeout: got=busy expected=idle at %0t", $time);
    end
  endtask

  task automatic do_commit(output int n);
    bus.commit = 1'b1;
    cyc();
    bus.commit = 1'b0;
    wait_idle(n);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  logic [NREQ-1:0] grants [4];
  int n;

  initial begin
    bus.req_valid = '0; bus.req_var = '0; bus.req_data = '0;
    bus.commit = 1'b0; bus.clr_ovf = 1'b0;
    repeat (2) cyc();
    chk("reset_var_q",    bus.var_q,    32'h0);
    chk("reset_busy",     bus.busy,     1'b0);
    chk("reset_change",   bus.change,   4'h0);
    chk("reset_overflow", bus.overflow, 1'b0);
    rst_n = 1'b1;
    cyc();

    // Arbitration: both valid for four cycles, all writes to var0.
    for (int c = 0; c < 4; c++) begin
      bus.req_valid = 2'b11;
      bus.req_var   = '0;
      bus.req_data  = {8'(8'h20 + c), 8'(8'h10 + c)};
      #1;
      grants[c] = bus.req_ready;
      @(posedge clk); #1;
    end
    bus.req_valid = '0;
    chk("arb_g0", grants[0], 2'b01);
    chk("arb_g1", grants[1], 2'b10);
    chk("arb_g2", grants[2], 2'b01);
    chk("arb_g3", grants[3], 2'b10);
    do_commit(n);
    chk("arb_busy_cycles", n, 5);
    chk("arb_var0", bus.var_q[7:0], 8'h23);
    chk("arb_change", bus.change, 4'b0001);

    // Two writes to var1 by one requester.
    enq(0, 1, 8'h00);
    enq(0, 1, 8'h01);
    do_commit(n);
    chk("t1_busy_cycles", n, 3);
    chk("t1_var1", bus.var_q[15:8], 8'h01);
    chk("t1_change", bus.change, 4'b0010);
    cyc();
    chk("t1_change_gone", bus.change, 4'b0000);

    // No net change on var2.
    enq(1, 2, 8'h05);
    do_commit(n);
    enq(0, 2, 8'h07);
    enq(1, 2, 8'h05);
    do_commit(n);
    chk("t2_busy_cycles", n, 3);
    chk("t2_change", bus.change, 4'b0000);
    chk("t2_var_q", bus.var_q, 32'h00050123);

    // Fill the queue, stall a ninth request, commit, then commit while busy.
    for (int i = 0; i < DEPTH; i++) enq(0, i % 4, 8'h30 + i);
    bus.req_valid = 2'b01;
    bus.req_var   = '0;
    bus.req_data  = 16'h00ff;
    #1;
    chk("t4_full_stall", bus.req_ready, 2'b00);
    cyc();
    bus.req_valid = '0;
    bus.commit = 1'b1;
    cyc();
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      cyc();
      if (n == 1) bus.commit = 1'b0;
    end
    bus.commit = 1'b0;
    chk("t4_busy_cycles", n, 9);
    chk("t4_overflow", bus.overflow, 1'b1);
    chk("t4_var_q", bus.var_q, 32'h37363534);
    chk("t4_change", bus.change, 4'b1111);
    bus.clr_ovf = 1'b1;
    cyc();
    bus.clr_ovf = 1'b0;
    chk("t4_clr_ovf", bus.overflow, 1'b0);
    // Clear and new overflow on the same edge: overflow stays set.
    bus.commit = 1'b1;
    cyc();
    bus.clr_ovf = 1'b1;
    cyc();
    bus.commit = 1'b0;
    bus.clr_ovf = 1'b0;
    chk("t4_ovf_priority", bus.overflow, 1'b1);
    bus.clr_ovf = 1'b1;
    cyc();
    bus.clr_ovf = 1'b0;
    chk("t4_clr_again", bus.overflow, 1'b0);

    // Reset in the middle of a drain.
    enq(0, 0, 8'h11);
    enq(1, 1, 8'h22);
    enq(0, 3, 8'h44);
    bus.commit = 1'b1;
    cyc();
    bus.commit = 1'b0;
    cyc();
    chk("t5_in_drain", bus.busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_var_q",  bus.var_q,  32'h0);
    chk("t5_rst_change", bus.change, 4'h0);
    chk("t5_rst_busy",   bus.busy,   1'b0);
    cyc();
    rst_n = 1'b1;
    cyc();
    do_commit(n);
    chk("t5_empty_busy_cycles", n, 1);
    chk("t5_empty_change", bus.change, 4'h0);

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      bus.req_valid = NREQ'($urandom_range(0, 3));
      bus.req_var   = (NREQ*VW)'($urandom);
      bus.req_data  = (NREQ*W)'($urandom);
      bus.commit    = ($urandom_range(0, 9) == 0);
      bus.clr_ovf   = ($urandom_range(0, 15) == 0);
      cyc();
    end
    bus.req_valid = '0; bus.commit = 1'b0; bus.clr_ovf = 1'b0;
    repeat (20) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
